// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and constants for the UART command sequencer
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ECHO   = 2'd2
    } state_t;

    localparam logic [7:0] CMD_RUN      = 8'h52;
    localparam logic [7:0] CMD_CLEAR    = 8'h43;
    localparam logic [7:0] CMD_HOUR     = 8'h48;
    localparam logic [7:0] CMD_MIN      = 8'h4D;
    localparam logic [7:0] CMD_SEC      = 8'h53;
    localparam logic [7:0] CMD_MODE     = 8'h58;
    localparam logic [7:0] CASE_BIT     = 8'h20;
    localparam logic [7:0] ERR_CHAR_DEF = 8'h3F;

    typedef struct packed {
        logic run;
        logic clear;
        logic hour;
        logic min;
        logic sec;
        logic mode;
    } cmd_t;

    // Forcing bit 5 folds upper and lower case letters onto the same code.
    function automatic logic [7:0] fold_case(input logic [7:0] b);
        return b | CASE_BIT;
    endfunction

endpackage

// File: rtl/uart_cmd_decode.sv
// rtl/uart_cmd_decode.sv - combinational ASCII byte to one-hot command decode
module uart_cmd_decode
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data_i,
    output cmd_t              cmd_o,
    output logic              match_o
);

    logic [7:0] folded;
    logic       hi_zero;

    // Bytes wider than 8 bits only match when the extra bits are clear.
    assign hi_zero = ~|(data_i >> 8);
    assign folded  = fold_case(data_i[7:0]);

    always_comb begin
        cmd_o       = '0;
        cmd_o.run   = hi_zero && (folded == fold_case(CMD_RUN));
        cmd_o.clear = hi_zero && (folded == fold_case(CMD_CLEAR));
        cmd_o.hour  = hi_zero && (folded == fold_case(CMD_HOUR));
        cmd_o.min   = hi_zero && (folded == fold_case(CMD_MIN));
        cmd_o.sec   = hi_zero && (folded == fold_case(CMD_SEC));
        cmd_o.mode  = hi_zero && (folded == fold_case(CMD_MODE));
    end

    assign match_o = |cmd_o;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - RX pop / decode / TX echo sequencer; echo path built under UART_CMD_ECHO_EN
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] ERR_CHAR  = DATA_W'(ERR_CHAR_DEF),
    parameter int                ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_empty,
    input  logic [DATA_W-1:0]    rx_rdata,
    output logic                 rx_rd,
    input  logic                 tx_full,
    output logic [DATA_W-1:0]    tx_wdata,
    output logic                 tx_wr,
    output logic                 run,
    output logic                 clear,
    output logic                 hour,
    output logic                 min,
    output logic                 sec,
    output logic                 mode,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_t               state_q;
    logic [DATA_W-1:0]    cmd_q;
    cmd_t                 pulse_q;
    logic [ERR_CNT_W-1:0] err_q;
    cmd_t                 dec_cmd;
    logic                 dec_match;

    uart_cmd_decode #(.DATA_W(DATA_W)) u_decode (
        .data_i  (cmd_q),
        .cmd_o   (dec_cmd),
        .match_o (dec_match)
    );

`ifdef UART_CMD_ECHO_EN
    logic              match_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] echo_byte;

    assign echo_byte = match_q ? cmd_q : ERR_CHAR;
`else
    logic unused_tx_full;

    assign unused_tx_full = tx_full;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            pulse_q <= '0;
            err_q   <= '0;
`ifdef UART_CMD_ECHO_EN
            match_q <= 1'b0;
            wdata_q <= '0;
`endif
        end else begin
            pulse_q <= '0;
            case (state_q)
                IDLE: begin
                    if (!rx_empty) begin
                        cmd_q   <= rx_rdata;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    pulse_q <= dec_cmd;
                    if (!dec_match && (err_q != '1)) begin
                        err_q <= err_q + 1'b1;
                    end
`ifdef UART_CMD_ECHO_EN
                    match_q <= dec_match;
                    state_q <= ECHO;
`else
                    state_q <= IDLE;
`endif
                end
`ifdef UART_CMD_ECHO_EN
                ECHO: begin
                    if (!tx_full) begin
                        wdata_q <= echo_byte;
                        state_q <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes and status are held low while reset is asserted, so an
    // in-flight byte produces no pulse or push once reset is seen.
    assign rx_rd = rst_n && (state_q == IDLE) && !rx_empty;
    assign busy  = rst_n && (state_q != IDLE);
    assign run   = rst_n && pulse_q.run;
    assign clear = rst_n && pulse_q.clear;
    assign hour  = rst_n && pulse_q.hour;
    assign min   = rst_n && pulse_q.min;
    assign sec   = rst_n && pulse_q.sec;
    assign mode  = rst_n && pulse_q.mode;

    assign err_cnt = err_q;

`ifdef UART_CMD_ECHO_EN
    assign tx_wr    = rst_n && (state_q == ECHO) && !tx_full;
    assign tx_wdata = tx_wr ? echo_byte : wdata_q;
`else
    assign tx_wr    = 1'b0;
    assign tx_wdata = '0;
`endif

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb/tb_uart_cmd_sequencer.sv - table-driven bench for uart_cmd_sequencer (both UART_CMD_ECHO_EN builds)
module tb_uart_cmd_sequencer;

`ifdef UART_CMD_ECHO_EN
    localparam bit ECHO_EN = 1'b1;
`else
    localparam bit ECHO_EN = 1'b0;
`endif
    localparam int PER = ECHO_EN ? 3 : 2;

    localparam logic [5:0] P0    = 6'b000000;
    localparam logic [5:0] RUN   = 6'b100000;
    localparam logic [5:0] CLEAR = 6'b010000;
    localparam logic [5:0] HOUR  = 6'b001000;
    localparam logic [5:0] MIN   = 6'b000100;
    localparam logic [5:0] SEC   = 6'b000010;
    localparam logic [5:0] MODE  = 6'b000001;

    logic       clk = 1'b0;
    logic       rst_n, rx_empty, rx_rd, tx_full, tx_wr;
    logic [7:0] rx_rdata, tx_wdata, err_cnt;
    logic       run, clear, hour, min, sec, mode, busy;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic       rst_n;
        logic       rx_empty;
        logic [7:0] rx_rdata;
        logic       tx_full;
        logic       rx_rd;
        logic [5:0] pulse;
        logic       tx_wr;
        logic [7:0] tx_wdata;
        logic       busy;
        logic [7:0] err_cnt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    uart_cmd_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_empty (rx_empty),
        .rx_rdata (rx_rdata),
        .rx_rd    (rx_rd),
        .tx_full  (tx_full),
        .tx_wdata (tx_wdata),
        .tx_wr    (tx_wr),
        .run      (run),
        .clear    (clear),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .mode     (mode),
        .busy     (busy),
        .err_cnt  (err_cnt)
    );

    task automatic add(input logic r, input logic e, input logic [7:0] d, input logic f,
                       input logic rd, input logic [5:0] p, input logic wr,
                       input logic [7:0] wd, input logic b, input logic [7:0] ec);
        vec_t v;
        v.rst_n = r; v.rx_empty = e; v.rx_rdata = d; v.tx_full = f;
        v.rx_rd = rd; v.pulse = p; v.tx_wr = wr; v.tx_wdata = wd; v.busy = b; v.err_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic e, input logic [7:0] d, input logic f);
        @(negedge clk);
        rst_n = r; rx_empty = e; rx_rdata = d; tx_full = f;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; rx_empty = 1'b0; rx_rdata = 8'h52; tx_full = 1'b0;

        if (ECHO_EN) begin
            add(0,0,8'h52,0, 0,P0,   0,8'h00,0,8'h00);
            add(1,0,8'h52,0, 1,P0,   0,8'h00,0,8'h00);
            add(1,1,8'h00,0, 0,P0,   0,8'h00,1,8'h00);
            add(1,1,8'h00,0, 0,RUN,  1,8'h52,1,8'h00);
            add(1,1,8'h00,0, 0,P0,   0,8'h52,0,8'h00);
            add(1,0,8'h7A,0, 1,P0,   0,8'h52,0,8'h00);
            add(1,1,8'h00,0, 0,P0,   0,8'h52,1,8'h00);
            add(1,1,8'h00,0, 0,P0,   1,8'h3F,1,8'h01);
            add(1,1,8'h00,0, 0,P0,   0,8'h3F,0,8'h01);
            add(1,0,8'h73,1, 1,P0,   0,8'h3F,0,8'h01);
            add(1,0,8'h68,1, 0,P0,   0,8'h3F,1,8'h01);
            add(1,0,8'h68,1, 0,SEC,  0,8'h3F,1,8'h01);
            for (int i = 0; i < 3; i++) add(1,0,8'h68,1, 0,P0,0,8'h3F,1,8'h01);
            add(1,0,8'h68,0, 0,P0,   1,8'h73,1,8'h01);
            add(1,0,8'h68,0, 1,P0,   0,8'h73,0,8'h01);
            add(1,0,8'h4D,0, 0,P0,   0,8'h73,1,8'h01);
            add(1,0,8'h4D,0, 0,HOUR, 1,8'h68,1,8'h01);
            add(1,0,8'h4D,0, 1,P0,   0,8'h68,0,8'h01);
            add(1,0,8'h78,0, 0,P0,   0,8'h68,1,8'h01);
            add(1,0,8'h78,0, 0,MIN,  1,8'h4D,1,8'h01);
            add(1,0,8'h78,0, 1,P0,   0,8'h4D,0,8'h01);
            add(1,1,8'h00,0, 0,P0,   0,8'h4D,1,8'h01);
            add(1,1,8'h00,0, 0,MODE, 1,8'h78,1,8'h01);
            add(1,0,8'h43,0, 1,P0,   0,8'h78,0,8'h01);
            add(1,1,8'h00,0, 0,P0,   0,8'h78,1,8'h01);
            add(0,1,8'h00,0, 0,P0,   0,8'h78,0,8'h01);
            add(1,1,8'h00,0, 0,P0,   0,8'h00,0,8'h00);
            add(1,0,8'h63,0, 1,P0,   0,8'h00,0,8'h00);
            add(1,1,8'h00,0, 0,P0,   0,8'h00,1,8'h00);
            add(1,1,8'h00,0, 0,CLEAR,1,8'h63,1,8'h00);
            add(1,1,8'h00,0, 0,P0,   0,8'h63,0,8'h00);
        end else begin
            add(0,0,8'h52,0, 0,P0,   0,8'h00,0,8'h00);
            add(1,0,8'h52,0, 1,P0,   0,8'h00,0,8'h00);
            add(1,1,8'h00,0, 0,P0,   0,8'h00,1,8'h00);
            add(1,1,8'h00,0, 0,RUN,  0,8'h00,0,8'h00);
            add(1,0,8'h7A,0, 1,P0,   0,8'h00,0,8'h00);
            add(1,1,8'h00,0, 0,P0,   0,8'h00,1,8'h00);
            add(1,1,8'h00,0, 0,P0,   0,8'h00,0,8'h01);
            add(1,0,8'h73,1, 1,P0,   0,8'h00,0,8'h01);
            add(1,0,8'h68,1, 0,P0,   0,8'h00,1,8'h01);
            add(1,0,8'h68,1, 1,SEC,  0,8'h00,0,8'h01);
            add(1,0,8'h4D,0, 0,P0,   0,8'h00,1,8'h01);
            add(1,0,8'h4D,0, 1,HOUR, 0,8'h00,0,8'h01);
            add(1,0,8'h78,0, 0,P0,   0,8'h00,1,8'h01);
            add(1,0,8'h78,0, 1,MIN,  0,8'h00,0,8'h01);
            add(1,1,8'h00,0, 0,P0,   0,8'h00,1,8'h01);
            add(1,1,8'h00,0, 0,MODE, 0,8'h00,0,8'h01);
            add(1,0,8'h43,0, 1,P0,   0,8'h00,0,8'h01);
            add(0,1,8'h00,0, 0,P0,   0,8'h00,0,8'h01);
            add(1,1,8'h00,0, 0,P0,   0,8'h00,0,8'h00);
            add(1,0,8'h63,0, 1,P0,   0,8'h00,0,8'h00);
            add(1,1,8'h00,0, 0,P0,   0,8'h00,1,8'h00);
            add(1,0,8'h52,0, 1,CLEAR,0,8'h00,0,8'h00);
            add(1,1,8'h00,0, 0,P0,   0,8'h00,1,8'h00);
            add(1,1,8'h00,0, 0,RUN,  0,8'h00,0,8'h00);
        end

        // First reset cycle leaves the state defined before the table starts.
        drive(0, 0, 8'h52, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            logic [5:0] pulse;
            drive(vecs[i].rst_n, vecs[i].rx_empty, vecs[i].rx_rdata, vecs[i].tx_full);
            #1;
            pulse = {run, clear, hour, min, sec, mode};
            tests_run++;
            if (rx_rd !== vecs[i].rx_rd || pulse !== vecs[i].pulse || tx_wr !== vecs[i].tx_wr ||
                tx_wdata !== vecs[i].tx_wdata || busy !== vecs[i].busy || err_cnt !== vecs[i].err_cnt) begin
                tests_failed++;
                $display("FAIL vec%0d: got rd=%b pulse=%b wr=%b wdata=%h busy=%b err=%h expected rd=%b pulse=%b wr=%b wdata=%h busy=%b err=%h",
                         i, rx_rd, pulse, tx_wr, tx_wdata, busy, err_cnt,
                         vecs[i].rx_rd, vecs[i].pulse, vecs[i].tx_wr, vecs[i].tx_wdata,
                         vecs[i].busy, vecs[i].err_cnt);
            end
        end

        // Saturation: 254 unknown bytes reach 8'hFE, 46 more must stop at 8'hFF.
        drive(0, 1, 8'h00, 0);
        for (int i = 0; i < 254 * PER; i++) drive(1, 0, 8'h7A, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 8'h00, 0);
        #1;
        check8("err_cnt_254", err_cnt, 8'hFE);
        check8("err_echo_char", tx_wdata, ECHO_EN ? 8'h3F : 8'h00);
        for (int i = 0; i < 46 * PER; i++) drive(1, 0, 8'h7A, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 8'h00, 0);
        #1;
        check8("err_cnt_sat", err_cnt, 8'hFF);
        check8("idle_after_sat", {7'd0, busy}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
